// File: rtl/reel_scroller_if.sv
// reel_scroller_if: control, row-lookup, glyph ROM and result signals of the two-reel scroller
interface reel_scroller_if;
    logic       spin_start;
    logic       stop_left;
    logic       stop_right;
    logic [2:0] current_row;
    logic [2:0] glyph_sym_l;
    logic [2:0] glyph_row_l;
    logic [7:0] glyph_data_l;
    logic [2:0] glyph_sym_r;
    logic [2:0] glyph_row_r;
    logic [7:0] glyph_data_r;
    logic [7:0] pixels_left;
    logic [7:0] pixels_right;
    logic       busy;
    logic       result_valid;
    logic [2:0] sym_left;
    logic [2:0] sym_right;
    logic       jackpot;
    modport master (
        output spin_start, stop_left, stop_right, current_row, glyph_data_l, glyph_data_r,
        input  glyph_sym_l, glyph_row_l, glyph_sym_r, glyph_row_r, pixels_left, pixels_right,
               busy, result_valid, sym_left, sym_right, jackpot
    );
    modport slave (
        input  spin_start, stop_left, stop_right, current_row, glyph_data_l, glyph_data_r,
        output glyph_sym_l, glyph_row_l, glyph_sym_r, glyph_row_r, pixels_left, pixels_right,
               busy, result_valid, sym_left, sym_right, jackpot
    );
endinterface

// File: rtl/reel_scroller.sv
// reel_scroller: two scrolling slot reels feeding glyph rows to an 8x8 dual-matrix scan driver
module reel_scroller #(
    parameter int STEP_TICKS_L = 1500000,
    parameter int STEP_TICKS_R = 1200000
) (
    input logic clk,
    input logic rst,
    reel_scroller_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SPIN, STOPPING} state_t;
    logic [1:0][2:0] sym_a, sym_na, gsym, grow;
    logic [1:0] idle, idle_nx, stop;
    logic start, settle, rv, jp;
    assign stop = {bus.stop_right, bus.stop_left};
    assign start = bus.spin_start && (&idle);
    assign settle = (&idle_nx) && !(&idle);
    genvar g;
    for (g = 0; g < 2; g++) begin : g_reel
        localparam int TICKS = g ? STEP_TICKS_R : STEP_TICKS_L;
        localparam int CW = $clog2(TICKS);
        state_t st, st_nx;
        logic [CW-1:0] cnt;
        logic [2:0] sym, off, sym_nx, off_nx;
        logic [3:0] idx;
        logic tick;
        assign tick = st != IDLE && cnt == CW'(TICKS - 1);
        always_comb begin
            off_nx = tick ? off + 3'd1 : off;
            sym_nx = tick && off == 3'd7 ? sym + 3'd1 : sym;
            st_nx = st == IDLE ? (start ? SPIN : IDLE) :
                    st == SPIN ? (stop[g] ? STOPPING : SPIN) :
                    (tick && off == 3'd7 ? IDLE : STOPPING);
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                st <= IDLE;
                cnt <= '0;
                sym <= '0;
                off <= '0;
            end else begin
                st <= st_nx;
                cnt <= st == IDLE || tick ? '0 : cnt + CW'(1);
                sym <= sym_nx;
                off <= off_nx;
            end
        end
        // rows past the bottom of the current symbol come from the next one down the strip
        assign idx = {1'b0, off} + {1'b0, bus.current_row};
        assign gsym[g] = idx[3] ? sym + 3'd1 : sym;
        assign grow[g] = idx[2:0];
        assign sym_a[g] = sym;
        assign sym_na[g] = sym_nx;
        assign idle[g] = st == IDLE;
        assign idle_nx[g] = st_nx == IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rv <= 1'b0;
            jp <= 1'b0;
        end else begin
            rv <= settle;
            jp <= start ? 1'b0 : settle ? sym_na[0] == sym_na[1] : jp;
        end
    end
    assign bus.glyph_sym_l = gsym[0];
    assign bus.glyph_row_l = grow[0];
    assign bus.glyph_sym_r = gsym[1];
    assign bus.glyph_row_r = grow[1];
    assign bus.pixels_left = bus.glyph_data_l;
    assign bus.pixels_right = bus.glyph_data_r;
    assign bus.busy = !(&idle);
    assign bus.result_valid = rv;
    assign bus.jackpot = jp;
    assign bus.sym_left = sym_a[0];
    assign bus.sym_right = sym_a[1];
endmodule

// File: tb/tb_reel_scroller.sv
// tb_reel_scroller: random spin/stop/reset stimulus against a strip-position model with a result scoreboard
module tb_reel_scroller;
    localparam int TL = 4;
    localparam int TR = 3;
    localparam int N = 20000;
    logic clk = 1'b0;
    logic rst = 1'b1;
    reel_scroller_if bus();
    reel_scroller #(.STEP_TICKS_L(TL), .STEP_TICKS_R(TR)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [7:0] rom(input logic [2:0] s, input logic [2:0] r);
        return {s, r, 2'b01};
    endfunction
    assign bus.glyph_data_l = rom(bus.glyph_sym_l, bus.glyph_row_l);
    assign bus.glyph_data_r = rom(bus.glyph_sym_r, bus.glyph_row_r);
    typedef struct {
        logic busy, rv, jp;
        logic [7:0] pl, pr;
        logic [2:0] sl, sr;
    } cyc_t;
    typedef struct {
        logic [2:0] sl, sr;
        logic jp;
    } res_t;
    cyc_t cyc_q[$];
    res_t res_q[$];
    int total = 0;
    int passed = 0;
    // model: each reel is a pixel-row position along an endless strip, symbol = pos/8, offset = pos%8
    int pos[2], phase[2], target[2];
    bit run[2], stopping[2];
    bit m_rv, m_jp, known;
    function automatic int period(input int k);
        return k == 0 ? TL : TR;
    endfunction
    function automatic logic [2:0] sym_of(input int p);
        return 3'((p / 8) % 8);
    endfunction
    function automatic logic [7:0] pix(input int p, input int cr);
        int q;
        q = p % 64 + cr;
        return rom(3'((q / 8) % 8), 3'(q % 8));
    endfunction
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else passed++;
    endtask
    task automatic advance(input bit r, input bit s, input bit [1:0] sp);
        bit both_idle, went, st_ok, step;
        if (r) begin
            for (int k = 0; k < 2; k++) begin
                pos[k] = 0;
                phase[k] = 0;
                run[k] = 0;
                stopping[k] = 0;
            end
            m_rv = 0;
            m_jp = 0;
            known = 1;
        end else begin
            both_idle = !run[0] && !run[1];
            st_ok = s && both_idle;
            went = 0;
            for (int k = 0; k < 2; k++) begin
                if (run[k]) begin
                    step = phase[k] == period(k) - 1;
                    phase[k] = step ? 0 : phase[k] + 1;
                    if (step) pos[k]++;
                    if (sp[k] && !stopping[k]) begin
                        stopping[k] = 1;
                        target[k] = (pos[k] / 8 + 1) * 8;
                    end else if (stopping[k] && pos[k] == target[k]) begin
                        run[k] = 0;
                        stopping[k] = 0;
                        phase[k] = 0;
                        went = 1;
                    end
                end else if (st_ok) begin
                    run[k] = 1;
                    phase[k] = 0;
                end
            end
            m_rv = went && !run[0] && !run[1];
            if (st_ok) m_jp = 0;
            else if (m_rv) m_jp = sym_of(pos[0]) == sym_of(pos[1]);
            if (m_rv) res_q.push_back('{sl: sym_of(pos[0]), sr: sym_of(pos[1]), jp: m_jp});
        end
    endtask
    always @(negedge clk) begin
        cyc_t e;
        res_t r;
        #1;
        if (cyc_q.size() != 0) begin
            e = cyc_q.pop_front();
            check("busy", 32'(bus.busy), 32'(e.busy));
            check("result_valid", 32'(bus.result_valid), 32'(e.rv));
            check("jackpot", 32'(bus.jackpot), 32'(e.jp));
            check("pixels_left", 32'(bus.pixels_left), 32'(e.pl));
            check("pixels_right", 32'(bus.pixels_right), 32'(e.pr));
            check("sym_left", 32'(bus.sym_left), 32'(e.sl));
            check("sym_right", 32'(bus.sym_right), 32'(e.sr));
        end
        if (bus.result_valid === 1'b1) begin
            if (res_q.size() == 0) check("unexpected_result", 32'd1, 32'd0);
            else begin
                r = res_q.pop_front();
                check("result_sym_left", 32'(bus.sym_left), 32'(r.sl));
                check("result_sym_right", 32'(bus.sym_right), 32'(r.sr));
                check("result_jackpot", 32'(bus.jackpot), 32'(r.jp));
            end
        end
    end
    initial begin
        bus.spin_start = 1'b0;
        bus.stop_left = 1'b0;
        bus.stop_right = 1'b0;
        bus.current_row = 3'd0;
        known = 0;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            rst = (i < 2) || (i == N - 1) || ($urandom % 600 == 0);
            bus.spin_start = $urandom % 16 == 0;
            bus.stop_left = $urandom % 12 == 0;
            bus.stop_right = $urandom % 12 == 0;
            bus.current_row = 3'($urandom % 8);
            if (known)
                cyc_q.push_back('{busy: run[0] || run[1], rv: m_rv, jp: m_jp,
                                  pl: pix(pos[0], int'(bus.current_row)),
                                  pr: pix(pos[1], int'(bus.current_row)),
                                  sl: sym_of(pos[0]), sr: sym_of(pos[1])});
            advance(rst, bus.spin_start, {bus.stop_right, bus.stop_left});
        end
        repeat (3) @(negedge clk);
        #3;
        check("results_drained", 32'(res_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
